cart_rom_fetch: RTL and testbench

//  Cartridge ROM fetch stage directly downstream of the mapper address output (mbc_addr).

---
 rtl/cart_fetch_pkg.sv | 11 +
 rtl/cart_rom_fetch_if.sv | 11 +
 rtl/fetch_word_buf.sv | 49 ++++
 rtl/cart_rom_fetch.sv | 113 +++++++++++
 tb/tb_cart_rom_fetch.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cart_fetch_pkg.sv
// cart_fetch_pkg: shared types for the cartridge ROM fetch stage
// exports WORD_AW (word address width), fetch_state_t and fetch_entry_t
package cart_fetch_pkg;
  localparam int WORD_AW = 22;
  typedef enum logic [1:0] {IDLE, DEMAND, PF} fetch_state_t;
  typedef struct packed {
    logic               valid;
    logic [WORD_AW-1:0] tag;
    logic [15:0]        data;
  } fetch_entry_t;
endpackage

// File: rtl/cart_rom_fetch_if.sv
// cart_rom_fetch_if: word-read handshake between the fetch stage and the SDRAM arbiter
// mem_req/mem_addr driven by master; mem_ack/mem_data driven by slave
interface cart_rom_fetch_if;
  import cart_fetch_pkg::*;
  logic               mem_req;
  logic [WORD_AW-1:0] mem_addr;
  logic               mem_ack;
  logic [15:0]        mem_data;
  modport master(output mem_req, mem_addr, input mem_ack, mem_data);
  modport slave(input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/fetch_word_buf.sv
// fetch_word_buf: two-entry word buffer (E0 demand, E1 prefetch) with tag compare and byte mux
// in: clk_sys, reset, clear, promote, fill0/fill1 with fill_tag/fill_data, byte addr
// out: hit0, hit1, tag1 (E1 tag), rom_di, rom_valid
module fetch_word_buf
  import cart_fetch_pkg::*;
(
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               clear,
  input  logic               promote,
  input  logic               fill0,
  input  logic               fill1,
  input  logic [WORD_AW-1:0] fill_tag,
  input  logic [15:0]        fill_data,
  input  logic [22:0]        addr,
  output logic               hit0,
  output logic               hit1,
  output logic [WORD_AW-1:0] tag1,
  output logic [7:0]         rom_di,
  output logic               rom_valid
);
  fetch_entry_t e0, e1;
  logic [15:0] word;
  // clear masks hits in the same cycle so disabling hides the buffer at once
  always_comb begin
    hit0 = e0.valid && !clear && e0.tag == addr[22:1];
    hit1 = e1.valid && !clear && e1.tag == addr[22:1];
    rom_valid = hit0 || hit1;
    word = hit0 ? e0.data : e1.data;
    rom_di = !rom_valid ? 8'hFF : addr[0] ? word[15:8] : word[7:0];
    tag1 = e1.tag;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      e0 <= '0;
      e1 <= '0;
    end else if (clear) begin
      e0.valid <= 1'b0;
      e1.valid <= 1'b0;
    end else begin
      if (promote) begin
        e0 <= e1;
        e1.valid <= 1'b0;
      end
      if (fill0) e0 <= '{1'b1, fill_tag, fill_data};
      if (fill1) e1 <= '{1'b1, fill_tag, fill_data};
    end
  end
endmodule

// File: rtl/cart_rom_fetch.sv
// cart_rom_fetch: turns mapped CPU ROM byte reads into buffered 16-bit SDRAM word reads
// in: clk_sys, reset, enable, cart_rd, mbc_addr; out: rom_di, rom_valid
// mem (master): one-outstanding word request handshake; out: stat_miss, stat_timeout
module cart_rom_fetch
  import cart_fetch_pkg::*;
#(
  parameter bit PREFETCH = 1'b1,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             enable,
  input  logic             cart_rd,
  input  logic [22:0]      mbc_addr,
  output logic [7:0]       rom_di,
  output logic             rom_valid,
  cart_rom_fetch_if.master mem,
  output logic [15:0]      stat_miss,
  output logic             stat_timeout
);
  fetch_state_t state, state_n;
  logic req, req_n, drop, drop_n, timeout_n, hit0, hit1, promote, fill0, fill1, lookup;
  logic [WORD_AW-1:0] addr, addr_n, tag1;
  logic [3:0] cnt, cnt_n;
  logic [15:0] miss_n;
  fetch_word_buf u_buf (
    .clk_sys,
    .reset,
    .clear(!enable),
    .promote,
    .fill0,
    .fill1,
    .fill_tag(addr),
    .fill_data(mem.mem_data),
    .addr(mbc_addr),
    .hit0,
    .hit1,
    .tag1,
    .rom_di,
    .rom_valid
  );
  assign mem.mem_req = req;
  assign mem.mem_addr = addr;
  assign lookup = state == IDLE && enable && cart_rd;
  // drop remembers that enable fell while a request was in flight, so its data is discarded
  // PF is entered with req low; the prefetch is issued one cycle later, which gives the
  // mandatory idle cycle after an ack
  always_comb begin
    state_n = state;
    req_n = req;
    addr_n = addr;
    cnt_n = (req && cnt != 4'(TIMEOUT)) ? cnt + 4'd1 : cnt;
    drop_n = drop | (req & ~enable);
    timeout_n = stat_timeout | (req & ~mem.mem_ack & (cnt == 4'(TIMEOUT)));
    miss_n = stat_miss;
    promote = 1'b0;
    fill0 = 1'b0;
    fill1 = 1'b0;
    case (state)
      IDLE:
        if (lookup && !hit0 && hit1) begin
          promote = 1'b1;
          state_n = PREFETCH ? PF : IDLE;
          addr_n = tag1;
        end else if (lookup && !hit0) begin
          state_n = DEMAND;
          req_n = 1'b1;
          addr_n = mbc_addr[22:1];
          cnt_n = '0;
          drop_n = 1'b0;
          miss_n = &stat_miss ? stat_miss : stat_miss + 16'd1;
        end
      DEMAND:
        if (mem.mem_ack) begin
          req_n = 1'b0;
          fill0 = ~drop_n;
          state_n = (PREFETCH && !drop_n) ? PF : IDLE;
        end
      PF:
        if (!req) begin
          state_n = enable ? PF : IDLE;
          req_n = enable;
          addr_n = enable ? addr + 22'd1 : addr;
          cnt_n = '0;
          drop_n = 1'b0;
        end else if (mem.mem_ack) begin
          req_n = 1'b0;
          fill1 = ~drop_n;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      req <= 1'b0;
      addr <= '0;
      cnt <= '0;
      drop <= 1'b0;
      stat_miss <= '0;
      stat_timeout <= 1'b0;
    end else begin
      state <= state_n;
      req <= req_n;
      addr <= addr_n;
      cnt <= cnt_n;
      drop <= drop_n;
      stat_miss <= miss_n;
      stat_timeout <= timeout_n;
    end
  end
endmodule

// File: tb/tb_cart_rom_fetch.sv
// tb_cart_rom_fetch: randomized self-checking bench with a transaction-level buffer model
module tb_cart_rom_fetch;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, cart_rd = 1'b0;
  logic [22:0] mbc_addr = '0;
  logic [7:0] rom_di;
  logic rom_valid, stat_timeout;
  logic [15:0] stat_miss;
  int n_chk = 0, n_err = 0;
  bit v0, v1;
  logic [21:0] t0, t1;
  int misses;
  cart_rom_fetch_if mem_if();
  cart_rom_fetch dut (
    .clk_sys(clk),
    .reset,
    .enable,
    .cart_rd,
    .mbc_addr,
    .rom_di,
    .rom_valid,
    .mem(mem_if),
    .stat_miss,
    .stat_timeout
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] rom_word(input logic [21:0] w);
    if (w == 22'h80) return 16'hBEEF;
    if (w == 22'h81) return 16'h1234;
    return w[15:0] ^ {w[21:16], w[9:0]} ^ 16'h5A3C;
  endfunction
  function automatic logic [7:0] rom_byte(input logic [22:0] a);
    logic [15:0] w;
    w = rom_word(a[22:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    cart_rd = 1'b0;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v0 = 0;
    v1 = 0;
    misses = 0;
  endtask
  // act as the arbiter for one request expected at word address ea
  task automatic serve(input logic [21:0] ea);
    int n = 0;
    int lat;
    while (!mem_if.mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(mem_if.mem_req), 32'd1);
    if (!mem_if.mem_req) return;
    chk("req_addr", 32'(mem_if.mem_addr), 32'(ea));
    lat = $urandom_range(0, 4);
    repeat (lat) begin
      @(negedge clk);
      chk("req_hold", 32'({mem_if.mem_req, mem_if.mem_addr}), 32'({1'b1, ea}));
    end
    mem_if.mem_ack = 1'b1;
    mem_if.mem_data = rom_word(ea);
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    mem_if.mem_data = 16'($urandom);
    chk("req_drop", 32'(mem_if.mem_req), 32'd0);
  endtask
  // one CPU read with the buffer quiescent; the model predicts hit/miss and the follow-up requests
  task automatic access(input logic [22:0] a);
    logic [21:0] t;
    bit h0, h1;
    t = a[22:1];
    h0 = v0 && t0 == t;
    h1 = v1 && t1 == t;
    @(negedge clk);
    mbc_addr = a;
    cart_rd = 1'b1;
    #1;
    chk("hit_valid", 32'(rom_valid), 32'(h0 | h1));
    chk("hit_data", 32'(rom_di), (h0 | h1) ? 32'(rom_byte(a)) : 32'hFF);
    @(negedge clk);
    cart_rd = 1'b0;
    if (!h0 && h1) begin
      v0 = 1; t0 = t; v1 = 0;
      serve(t + 22'd1);
      v1 = 1; t1 = t + 22'd1;
    end else if (!h0) begin
      misses++;
      chk("miss_nodata", 32'(rom_valid), 32'd0);
      serve(t);
      v0 = 1; t0 = t;
      #1;
      chk("fill_valid", 32'(rom_valid), 32'd1);
      chk("fill_data", 32'(rom_di), 32'(rom_byte(a)));
      serve(t + 22'd1);
      v1 = 1; t1 = t + 22'd1;
    end
    chk("stat_miss", 32'(stat_miss), 32'(misses));
  endtask
  initial begin
    logic [22:0] base;
    int r;
    do_reset();
    #1;
    chk("rst_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("rst_valid", 32'(rom_valid), 32'd0);
    chk("rst_di", 32'(rom_di), 32'hFF);
    chk("rst_miss", 32'(stat_miss), 32'd0);
    chk("rst_to", 32'(stat_timeout), 32'd0);
    enable = 1'b1;
    access(23'h000100);
    chk("t1_di", 32'(rom_di), 32'hEF);
    chk("t1_miss", 32'(stat_miss), 32'd1);
    access(23'h000101);
    chk("t2_di", 32'(rom_di), 32'hBE);
    access(23'h000102);
    chk("t3_di", 32'(rom_di), 32'h34);
    access(23'h7FFFFE);
    access(23'h000001);
    @(negedge clk);
    enable = 1'b0;
    #1;
    chk("dis_valid", 32'(rom_valid), 32'd0);
    chk("dis_di", 32'(rom_di), 32'hFF);
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    mbc_addr = 23'h000200;
    cart_rd = 1'b1;
    @(negedge clk);
    cart_rd = 1'b0;
    chk("t5_req", 32'({mem_if.mem_req, mem_if.mem_addr}), 32'({1'b1, 22'h100}));
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_hold", 32'({mem_if.mem_req, mem_if.mem_addr}), 32'({1'b1, 22'h100}));
    end
    mem_if.mem_ack = 1'b1;
    mem_if.mem_data = rom_word(22'h100);
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    cart_rd = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_noreq", 32'(mem_if.mem_req), 32'd0);
      chk("t5_novalid", 32'(rom_valid), 32'd0);
    end
    cart_rd = 1'b0;
    enable = 1'b1;
    misses = 1;
    v0 = 0;
    v1 = 0;
    access(23'h000200);
    base = 23'h001234;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) base = 23'($urandom);
      else if (r == 1) base = 23'h7FFFF8;
      else if (r == 2) begin
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        v0 = 0;
        v1 = 0;
      end
      access(23'(base + 23'($urandom_range(0, 11))));
    end
    chk("rand_to", 32'(stat_timeout), 32'd0);
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    mbc_addr = 23'h001000;
    cart_rd = 1'b1;
    @(negedge clk);
    cart_rd = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("t6_req", 32'(mem_if.mem_req), 32'd1);
      if (k == 15) chk("t6_to15", 32'(stat_timeout), 32'd0);
      if (k == 16) chk("t6_to16", 32'(stat_timeout), 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_req", 32'(mem_if.mem_req), 32'd0);
    chk("t6_rst_to", 32'(stat_timeout), 32'd0);
    chk("t6_rst_miss", 32'(stat_miss), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
